// File: rtl/dmem_responder_if.sv
// Request/response bundle between the LSU (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, byte-lane stores and
// extended loads. Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them.
module dmem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            error_q, error_d;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem [MEM_WORDS];

    logic            accept;
    logic            commit;
    logic            misaligned;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic [31:0]     shifted;
    logic [31:0]     load_data;
    logic            unused_addr;

    assign accept      = (state_q == StIdle) && bus.req_valid;
    assign commit      = (state_q == StWait) && (cnt_q == 4'd0);
    assign idx         = addr_q[AW+1:2];
    assign word        = mem[idx];
    assign unused_addr = ^bus.req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                        (funct3_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane is forced to the access size; with trapping enabled the misaligned cases never commit.
    always_comb begin
        lane = 2'b00;
        be   = 4'b1111;
        case (funct3_q[1:0])
            2'b00: begin
                lane = addr_q[1:0];
                be   = 4'b0001 << lane;
            end
            2'b01: begin
                lane = {addr_q[1], 1'b0};
                be   = 4'b0011 << lane;
            end
            default: begin
                lane = 2'b00;
                be   = 4'b1111;
            end
        endcase
    end

    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        load_data = word;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                if (commit) begin
                    state_d = StResp;
                    error_d = misaligned;
                    rdata_d = (write_q || misaligned) ? 32'h0 : load_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr[AW+1:0];
            wdata_q  <= bus.req_wdata;
        end
    end

    // A reset in the commit cycle abandons the store.
    always_ff @(posedge clk) begin
        if (!reset && commit && write_q && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus reset and stall sequences.
module tb_dmem_responder;
    localparam int W = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .MEM_WORDS  (1024),
        .WAIT_CYCLES(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err);
        vec_t v;
        v.write     = wr;
        v.f3        = f3;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = rdata;
        v.exp_err   = err;
        return v;
    endfunction

    task automatic txn(input string tag, input vec_t v, input int hold);
        int          n;
        int          k;
        exp_t        e;
        logic [31:0] held_rdata;
        logic        held_err;
        @(negedge clk);
        bus.req_write  = v.write;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 50) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(k), 32'(1 + W));
        if (!bus.rsp_valid) begin
            void'(sb.pop_front());
            return;
        end
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_error;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'h1);
            check({tag, "_stall_rdata"}, bus.rsp_rdata, held_rdata);
            check({tag, "_stall_err"}, 32'(bus.rsp_error), 32'(held_err));
            check({tag, "_stall_req_ready"}, 32'(bus.req_ready), 32'h0);
        end
        e = sb.pop_front();
        check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({tag, "_err"}, 32'(bus.rsp_error), 32'(e.err));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_idle_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_idle_req_ready"}, 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        reset          = 1'b1;

        vecs.push_back(mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h13, 32'h80000000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h12, 32'h0, 32'h00000022, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8022, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h1010, 32'h0, 32'h80223344, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h22, 32'hBEEF0000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h20, 32'h0, 32'h00000000, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h40, 32'h80017FFF, 32'h0, 1'b0));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 3'b010, 32'h42, 32'hAAAAAAAA, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0, 32'h80017FFF, 1'b0));
`else
        vecs.push_back(mk(1'b0, 3'b001, 32'h41, 32'h0, 32'h00007FFF, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h42, 32'hAAAAAAAA, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAAAAAA, 1'b0));
`endif
        vecs.push_back(mk(1'b1, 3'b010, 32'h30, 32'hCAFEBABE, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEBABE, 1'b0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'h1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset_rsp_error", 32'(bus.rsp_error), 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            txn($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Response held for three cycles with rsp_ready low.
        txn("stall", mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0), 3);

        // Reset during the wait of a store: the store must not land.
        @(negedge clk);
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h12345678;
        bus.req_valid  = 1'b1;
        check("rst_seq_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_seq_in_wait", 32'(bus.req_ready), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_seq_req_ready_after", 32'(bus.req_ready), 32'h1);
        check("rst_seq_rsp_valid_after", 32'(bus.rsp_valid), 32'h0);
        check("rst_seq_rsp_rdata_after", bus.rsp_rdata, 32'h0);
        check("rst_seq_rsp_error_after", 32'(bus.rsp_error), 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("rst_seq_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        txn("rst_seq_load", mk(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEBABE, 1'b0), 0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
